uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_bit_sampler.sv | 53 +++++
 rtl/uart_rx_cfg.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parameter
// defaults, legal configuration ranges and the 2-of-3 majority helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int OVERSAMPLE_MIN     = 8;
    localparam int OVERSAMPLE_MAX     = 16;
    localparam int DATA_BITS_MIN      = 5;
    localparam int DATA_BITS_MAX      = 9;
    localparam int STOP_BITS_MIN      = 1;
    localparam int STOP_BITS_MAX      = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Input synchronizer, start-edge detector and 3-sample majority voter placed
// around the middle of each bit period.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          sample_tick,
    input  logic [$clog2(OVERSAMPLE)-1:0] tick_cnt,
    output logic                          fall,
    output logic                          vote,
    output logic                          vote_valid
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_A = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_B = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_C = TW'(OVERSAMPLE / 2 + 1);

    logic sync1, sync2, prev;
    logic samp_a, samp_b;

    // Preset to idle-high so reset release never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (sample_tick) begin
            if (tick_cnt == TICK_A) samp_a <= sync2;
            if (tick_cnt == TICK_B) samp_b <= sync2;
        end
    end

    // The third sample is voted live so the decision lands on its own tick
    assign fall       = prev & ~sync2;
    assign vote_valid = sample_tick && (tick_cnt == TICK_C);
    assign vote       = majority3(samp_a, samp_b, sync2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with ready/valid output, frame error, overrun and
// break detection. Define UART_RX_PARITY_EN to add a parity bit and its check.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS=%0d is outside 5..9", DATA_BITS);
    end
    if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_cfg: OVERSAMPLE=%0d must be even within 8..16", OVERSAMPLE);
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
    end

    uart_state_t          state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop2_q, stop2_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 fall, vote, vote_valid;
    logic                 word_done, word_ferr, brk_pulse, leave_stop;
    logic                 par_low;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic word_perr;
    assign par_low   = ~par_q;
    assign word_perr = ((^shift_q) ^ par_q) != parity_odd;
`else
    assign par_low    = 1'b1;
    assign parity_err = 1'b0;
`endif

    uart_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .sample_tick (sample_tick),
        .tick_cnt    (tick_q),
        .fall        (fall),
        .vote        (vote),
        .vote_valid  (vote_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            stop2_q <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            stop2_q <= stop2_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        stop2_d    = stop2_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
`endif
        word_done  = 1'b0;
        word_ferr  = 1'b0;
        brk_pulse  = 1'b0;
        leave_stop = 1'b0;

        if (state_q != ST_IDLE && sample_tick)
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;

        case (state_q)
            ST_START: begin
                if (vote_valid) state_d = vote ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (vote_valid) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (vote_valid) begin
                    par_d   = vote;
                    state_d = ST_STOP;
                end
            end
`endif
            // A break parks here until the line is seen high again
            ST_STOP: begin
                if (vote_valid) begin
                    if (brk_q) begin
                        leave_stop = vote;
                    end else if (stop2_q) begin
                        word_done  = 1'b1;
                        word_ferr  = ferr_q | ~vote;
                        leave_stop = 1'b1;
                    end else if (!vote && shift_q == '0 && par_low) begin
                        brk_pulse = 1'b1;
                        brk_d     = 1'b1;
                    end else if (STOP_BITS == 2) begin
                        stop2_d = 1'b1;
                        ferr_d  = ~vote;
                    end else begin
                        word_done  = 1'b1;
                        word_ferr  = ~vote;
                        leave_stop = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // IDLE and the exit from STOP share the start-edge arming logic
        if (state_q == ST_IDLE || leave_stop) begin
            tick_d  = '0;
            state_d = ST_IDLE;
            if (fall) begin
                state_d = ST_START;
                bit_d   = '0;
                stop2_d = 1'b0;
                ferr_d  = 1'b0;
                brk_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            break_det <= brk_pulse;
            if (word_done && data_valid && !data_ready) begin
                overrun <= 1'b1;
            end else if (word_done) begin
                data_out   <= shift_q;
                frame_err  <= word_ferr;
`ifdef UART_RX_PARITY_EN
                parity_err <= word_perr;
`endif
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized
// frames compared against a frame-level reference model.
module tb_uart_rx_cfg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int STOP_BITS  = 1;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 ferr;
        logic                 perr;
    } word_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 sample_tick;
    logic                 rx;
    logic                 parity_odd;
    logic                 data_ready;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid, frame_err, parity_err, overrun, break_det, busy;

    int checks       = 0;
    int failures     = 0;
    int valid_cycles = 0;
    int overrun_cnt  = 0;
    int break_cnt    = 0;
    int hold_viol    = 0;
    word_t got_q[$];

    uart_rx_cfg #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .STOP_BITS  (STOP_BITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rx          (rx),
`ifdef UART_RX_PARITY_EN
        .parity_odd  (parity_odd),
`endif
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .break_det   (break_det),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        sample_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    // Observes accepted words, pulses and hold-while-stalled behaviour
    initial begin : monitor
        logic  prev_valid, prev_ready;
        word_t prev_word, cur;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            #2;
            cur = '{data: data_out, ferr: frame_err, perr: parity_err};
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (data_valid) valid_cycles++;
                if (overrun) overrun_cnt++;
                if (break_det) break_cnt++;
                if (prev_valid && !prev_ready && (!data_valid || cur !== prev_word)) hold_viol++;
                if (data_valid && data_ready) got_q.push_back(cur);
                prev_valid = data_valid;
                prev_ready = data_ready;
                prev_word  = cur;
            end
        end
    end

    // Reference model: parity bit a correct transmitter would send, and the
    // error flag the receiver should report for a given received parity bit
    function automatic logic good_par(input logic [DATA_BITS-1:0] d, input logic odd);
        return logic'(($countones(d) + (odd ? 1 : 0)) % 2);
    endfunction

    function automatic logic exp_perr(input logic [DATA_BITS-1:0] d, input logic p, input logic odd);
        if (!PAR_EN) return 1'b0;
        return logic'((($countones(d) + (p ? 1 : 0)) % 2) != (odd ? 1 : 0));
    endfunction

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic p, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(p);
        for (int i = 0; i < STOP_BITS; i++) drive_bit(stop);
    endtask

    task automatic expect_one_word(input string name, input word_t e);
        word_t w;
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL %s_count got=%0d exp=1", name, got_q.size());
        end else begin
            w = got_q.pop_front();
            checks++;
            if (w !== e) begin
                failures++;
                $display("[TB] FAIL %s_word got=%h/f%b/p%b exp=%h/f%b/p%b",
                         name, w.data, w.ferr, w.perr, e.data, e.ferr, e.perr);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        data_ready = 1'b1;
        parity_odd = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_out, data_valid, frame_err, parity_err, overrun, break_det, busy} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h exp=0",
                     {data_out, data_valid, frame_err, parity_err, overrun, break_det, busy});
        end
        rst_n = 1'b1;
        idle_bits(2);
        checks++;
        if (busy !== 1'b0 || valid_cycles != 0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset busy=%b valid_cycles=%0d exp busy=0 valid_cycles=0",
                     busy, valid_cycles);
        end
    endtask

    task automatic test_basic();
        int v0, o0;
        v0 = valid_cycles;
        o0 = overrun_cnt;
        got_q.delete();
        data_ready = 1'b1;
        send_frame(8'h5A, good_par(8'h5A, parity_odd), 1'b1);
        expect_one_word("basic", '{data: 8'h5A, ferr: 1'b0, perr: 1'b0});
        checks++;
        if (valid_cycles - v0 != 1) begin
            failures++;
            $display("[TB] FAIL basic_valid_len got=%0d exp=1", valid_cycles - v0);
        end
        checks++;
        if (busy !== 1'b0 || overrun_cnt != o0) begin
            failures++;
            $display("[TB] FAIL basic_idle busy=%b overruns=%0d exp busy=0 overruns=0", busy, overrun_cnt - o0);
        end
    endtask

    task automatic test_glitch();
        int v0;
        v0 = valid_cycles;
        got_q.delete();
        rx = 1'b0;
        repeat (BIT_CLKS / 4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL glitch_busy_rise got=%b exp=1", busy);
        end
        drive_bit(1'b1);
        checks++;
        if (busy !== 1'b0 || valid_cycles != v0 || got_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL glitch_reject busy=%b valids=%0d exp busy=0 valids=0", busy, valid_cycles - v0);
        end
    endtask

    task automatic test_overrun();
        int o0, h0;
        o0 = overrun_cnt;
        h0 = hold_viol;
        got_q.delete();
        data_ready = 1'b0;
        send_frame(8'h41, good_par(8'h41, parity_odd), 1'b1);
        send_frame(8'h42, good_par(8'h42, parity_odd), 1'b1);
        idle_bits(1);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h41) begin
            failures++;
            $display("[TB] FAIL overrun_hold valid=%b data=%h exp valid=1 data=41", data_valid, data_out);
        end
        checks++;
        if (overrun_cnt - o0 != 1) begin
            failures++;
            $display("[TB] FAIL overrun_pulses got=%0d exp=1", overrun_cnt - o0);
        end
        checks++;
        if (hold_viol != h0) begin
            failures++;
            $display("[TB] FAIL overrun_stable violations=%0d exp=0", hold_viol - h0);
        end
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        expect_one_word("overrun_accept", '{data: 8'h41, ferr: 1'b0, perr: 1'b0});
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overrun_drop valid=%b exp=0", data_valid);
        end
        data_ready = 1'b1;
    endtask

    task automatic test_frame_break();
        int b0, v1;
        b0 = break_cnt;
        got_q.delete();
        data_ready = 1'b1;
        send_frame(8'h33, good_par(8'h33, parity_odd), 1'b0);
        expect_one_word("frame_err", '{data: 8'h33, ferr: 1'b1, perr: 1'b0});
        idle_bits(2);
        v1 = valid_cycles;
        for (int i = 0; i < 12; i++) drive_bit(1'b0);
        idle_bits(2);
        checks++;
        if (break_cnt - b0 != 1) begin
            failures++;
            $display("[TB] FAIL break_pulses got=%0d exp=1", break_cnt - b0);
        end
        checks++;
        if (valid_cycles != v1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL break_no_word valids=%0d busy=%b exp valids=0 busy=0", valid_cycles - v1, busy);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        data_ready = 1'b1;
        parity_odd = 1'b0;
        got_q.delete();
        send_frame(8'h07, 1'b0, 1'b1);
        expect_one_word("parity_bad", '{data: 8'h07, ferr: 1'b0, perr: 1'b1});
        send_frame(8'h07, 1'b1, 1'b1);
        expect_one_word("parity_good", '{data: 8'h07, ferr: 1'b0, perr: 1'b0});
        parity_odd = 1'b1;
        send_frame(8'h07, 1'b0, 1'b1);
        expect_one_word("parity_odd", '{data: 8'h07, ferr: 1'b0, perr: 1'b0});
        parity_odd = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        data_ready = 1'b0;
        got_q.delete();
        send_frame(8'hA5, good_par(8'hA5, parity_odd), 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        checks++;
        if ({busy, data_valid} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL mid_frame_state busy/valid=%b exp=11", {busy, data_valid});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out, data_valid, frame_err, parity_err, overrun, break_det, busy} !== '0) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs got=%h exp=0",
                     {data_out, data_valid, frame_err, parity_err, overrun, break_det, busy});
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        data_ready = 1'b1;
        got_q.delete();
        send_frame(8'hC3, good_par(8'hC3, parity_odd), 1'b1);
        expect_one_word("after_reset", '{data: 8'hC3, ferr: 1'b0, perr: 1'b0});
    endtask

    task automatic test_random();
        data_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            logic [DATA_BITS-1:0] d;
            logic  p, s, odd, is_brk;
            int    b0;
            word_t e;
            d   = DATA_BITS'($urandom);
            odd = 1'($urandom);
            p   = good_par(d, odd);
            if ($urandom_range(0, 3) == 0) p = ~p;
            s   = ($urandom_range(0, 3) != 0);
            if (n == 3) begin
                d = '0;
                p = 1'b0;
                s = 1'b0;
            end
            parity_odd = odd;
            is_brk = (d == '0) && !s && (!PAR_EN || !p);
            got_q.delete();
            b0 = break_cnt;
            send_frame(d, p, s);
            if (is_brk) begin
                checks++;
                if (break_cnt - b0 != 1 || got_q.size() != 0) begin
                    failures++;
                    $display("[TB] FAIL rand_break n=%0d breaks=%0d words=%0d exp breaks=1 words=0",
                             n, break_cnt - b0, got_q.size());
                end
            end else begin
                e = '{data: d, ferr: ~s, perr: exp_perr(d, p, odd)};
                expect_one_word("rand", e);
            end
            if (!s) idle_bits(2);
            else idle_bits($urandom_range(0, 1));
        end
        parity_odd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rx = 1'b1;
        data_ready = 1'b1;
        parity_odd = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_overrun();
        test_frame_break();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
